lcd_stream_gen: RTL and testbench

//  Source end of the LCD pixel stream (clkena/data/mode/on) consumed by the LCD scan-doubler.

---
 rtl/lcd_stream_gen_if.sv | 8 +
 rtl/lcd_stream_gen.sv | 85 ++++++++
 tb/tb_lcd_stream_gen.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_stream_gen_if.sv
// lcd_stream_gen_if: upstream pixel valid/ready handshake feeding the LCD stream generator.
interface lcd_stream_gen_if #(parameter int DW = 15);
    logic          pix_valid;
    logic [DW-1:0] pix_data;
    logic          pix_ready;
    modport master (output pix_valid, pix_data, input pix_ready);
    modport slave  (input pix_valid, pix_data, output pix_ready);
endinterface

// File: rtl/lcd_stream_gen.sv
// lcd_stream_gen: Game Boy LCD dot/line timing and pixel stream source for the scan-doubler.
// Pulls pixels from a valid/ready source and pads late lines so every visible line gets PIX_W strobes.
module lcd_stream_gen #(
    parameter int LINE_DOTS = 456,
    parameter int LINES     = 154,
    parameter int VIS_LINES = 144,
    parameter int OAM_DOTS  = 80,
    parameter int PRE_DOTS  = 12,
    parameter int PIX_W     = 160,
    parameter int DW        = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ce,
    input  logic            lcd_on_in,
    lcd_stream_gen_if.slave pix,
    output logic            lcd_clkena,
    output logic [DW-1:0]   lcd_data,
    output logic [1:0]      lcd_mode,
    output logic            lcd_on,
    output logic [7:0]      ly,
    output logic            frame_start,
    output logic            underrun
);
    logic [8:0] dot, dot_n;
    logic [7:0] px_cnt, px_n, ly_n;
    logic [1:0] mode_n;
    logic [9:0] dots_left, pix_left;
    logic       line_end, pad_active, pad, xfer, strobe;

    assign line_end  = dot == 9'(LINE_DOTS - 1);
    assign dots_left = 10'(LINE_DOTS) - 10'(dot);
    assign pix_left  = 10'(PIX_W) - 10'(px_cnt);
    // Padding starts once the remaining dots exactly cover the missing pixels, then holds to line end.
    assign pad = lcd_mode == 2'd3 && (pad_active || (!pix.pix_valid && dots_left == pix_left));
    assign pix.pix_ready = ce && lcd_on_in && lcd_mode == 2'd3 && dot >= 9'(OAM_DOTS + PRE_DOTS)
                         && px_cnt < 8'(PIX_W) && !pad;
    assign xfer   = pix.pix_valid && pix.pix_ready;
    assign strobe = xfer || pad;

    always_comb begin
        dot_n  = (!lcd_on || line_end) ? 9'd0 : dot + 9'd1;
        ly_n   = !lcd_on ? 8'd0 : !line_end ? ly : (ly == 8'(LINES - 1)) ? 8'd0 : ly + 8'd1;
        px_n   = (!lcd_on || line_end) ? 8'd0 : px_cnt + {7'd0, strobe};
        mode_n = ly_n >= 8'(VIS_LINES) ? 2'd1 : dot_n < 9'(OAM_DOTS) ? 2'd2 : px_n < 8'(PIX_W) ? 2'd3 : 2'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dot         <= '0;
            ly          <= '0;
            px_cnt      <= '0;
            lcd_mode    <= '0;
            lcd_on      <= 1'b0;
            lcd_clkena  <= 1'b0;
            lcd_data    <= '0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            pad_active  <= 1'b0;
        end else if (!ce) begin
            lcd_clkena  <= 1'b0;
            frame_start <= 1'b0;
        end else if (!lcd_on_in) begin
            dot         <= '0;
            ly          <= '0;
            px_cnt      <= '0;
            lcd_mode    <= '0;
            lcd_on      <= 1'b0;
            lcd_clkena  <= 1'b0;
            frame_start <= 1'b0;
            pad_active  <= 1'b0;
        end else begin
            dot         <= dot_n;
            ly          <= ly_n;
            px_cnt      <= px_n;
            lcd_mode    <= mode_n;
            lcd_on      <= 1'b1;
            lcd_clkena  <= strobe;
            frame_start <= dot_n == 9'd0 && ly_n == 8'd0;
            pad_active  <= pad && !line_end;
            if (strobe) lcd_data <= pad ? '0 : pix.pix_data;
            if (pad) underrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_lcd_stream_gen.sv
// tb_lcd_stream_gen: directed and randomized checks of lcd_stream_gen against a tick-count reference model.
module tb_lcd_stream_gen;
    localparam int LD = 456, LN = 20, VL = 16, OAM = 80, PRE = 12, PW = 160, DW = 15;
    localparam int FRAME = LD * LN;

    logic clk = 1'b0, reset = 1'b0, ce = 1'b0, lcd_on_in = 1'b0;
    logic lcd_clkena, lcd_on, frame_start, underrun;
    logic [DW-1:0] lcd_data;
    logic [1:0] lcd_mode;
    logic [7:0] ly;

    lcd_stream_gen_if #(.DW(DW)) pix ();

    lcd_stream_gen #(.LINES(LN), .VIS_LINES(VL), .DW(DW)) dut (
        .clk(clk), .reset(reset), .ce(ce), .lcd_on_in(lcd_on_in), .pix(pix),
        .lcd_clkena(lcd_clkena), .lcd_data(lcd_data), .lcd_mode(lcd_mode), .lcd_on(lcd_on),
        .ly(ly), .frame_start(frame_start), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    bit m_on, m_pad, m_und, e_stb, e_fs, have_fs;
    int tick, m_px, fs_gap, fs_cnt, m1_cnt;
    logic [DW-1:0] e_data = '0, src = '0;
    int stb_n[LN], zd_n[LN], m3_n[LN];
    logic [DW-1:0] fd[LN], lst[LN];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference: position is a plain tick count within the frame; mode follows from position and pixel count.
    function automatic logic [1:0] mmode();
        int d, l;
        d = tick % LD;
        l = tick / LD;
        if (!m_on) return 2'd0;
        if (l >= VL) return 2'd1;
        if (d < OAM) return 2'd2;
        return m_px < PW ? 2'd3 : 2'd0;
    endfunction

    function automatic bit mpad();
        return mmode() == 2'd3 && (m_pad || (!pix.pix_valid && (LD - tick % LD) == (PW - m_px)));
    endfunction

    function automatic bit mready();
        return ce && lcd_on_in && mmode() == 2'd3 && (tick % LD) >= OAM + PRE && m_px < PW && !mpad();
    endfunction

    task automatic clr();
        for (int i = 0; i < LN; i++) begin
            stb_n[i] = 0; zd_n[i] = 0; m3_n[i] = 0; fd[i] = '0; lst[i] = '0;
        end
        fs_cnt = 0;
        m1_cnt = 0;
    endtask

    task automatic step(input bit c, input bit on, input bit v);
        bit rdy, pd, xf, stb;
        int pl;
        ce = c;
        lcd_on_in = on;
        pix.pix_valid = v;
        pix.pix_data = v ? src : DW'($urandom);
        #3;
        rdy = mready();
        pd = mpad();
        chk("pix_ready", {63'd0, pix.pix_ready}, {63'd0, rdy});
        xf = v && rdy;
        stb = xf || pd;
        @(posedge clk);
        pl = tick / LD;
        if (!c) begin
            e_stb = 0; e_fs = 0;
        end else if (!on) begin
            m_on = 0; tick = 0; m_px = 0; m_pad = 0; e_stb = 0; e_fs = 0; have_fs = 0;
        end else if (!m_on) begin
            m_on = 1; tick = 0; m_px = 0; m_pad = 0; e_stb = 0; e_fs = 1;
        end else begin
            e_stb = stb;
            if (stb) e_data = pd ? '0 : pix.pix_data;
            if (pd) m_und = 1;
            m_pad = pd;
            m_px += int'(stb);
            if (tick % LD == LD - 1) begin m_px = 0; m_pad = 0; end
            tick = (tick + 1) % FRAME;
            e_fs = tick == 0;
        end
        if (xf) src++;
        #1;
        chk("outs", {35'd0, lcd_clkena, lcd_clkena ? lcd_data : {DW{1'b0}}, lcd_mode, lcd_on, ly, frame_start, underrun},
                    {35'd0, e_stb, e_stb ? e_data : {DW{1'b0}}, mmode(), m_on, 8'(tick / LD), e_fs, m_und});
        if (!c) begin
            chk("stb_width", {63'd0, lcd_clkena}, 64'd0);
            chk("fs_width", {63'd0, frame_start}, 64'd0);
        end else begin
            if (lcd_clkena) begin
                stb_n[pl]++;
                if (lcd_data == '0) zd_n[pl]++;
                if (stb_n[pl] == 1) fd[pl] = lcd_data;
                lst[pl] = lcd_data;
            end
            if (lcd_mode == 2'd3) m3_n[tick / LD]++;
            if (lcd_mode == 2'd1) m1_cnt++;
            fs_gap++;
            if (frame_start) begin
                if (have_fs) chk("fs_period", 64'(fs_gap), 64'(FRAME));
                have_fs = 1;
                fs_gap = 0;
                fs_cnt++;
            end
        end
    endtask

    task automatic run(input int n, input int cm, input int vm, input int l);
        for (int k = 0; k < n && errors < 200; k++) begin
            int d, y;
            bit c, v, on;
            d = tick % LD;
            y = tick / LD;
            if (cm == 0) c = 1'b1;
            else if (cm == 1) c = (k % 2) == 0;
            else c = ($urandom % 3) != 0;
            on = cm == 2 ? ($urandom % 3000) != 0 : 1'b1;
            if (vm == 1) v = !(y == l && d >= OAM + PRE + 51 && d < OAM + PRE + 71);
            else if (vm == 2) v = y != l;
            else if (vm == 3) v = ($urandom % 8) != 0;
            else v = 1'b1;
            step(c, on, v);
        end
    endtask

    task automatic run_to(input int y, input int d);
        int n = 0;
        while (!(m_on && tick == y * LD + d) && n < FRAME + 4 && errors < 200) begin
            step(1'b1, 1'b1, 1'b1);
            n++;
        end
        chk("run_to_reached", {63'd0, m_on && tick == y * LD + d}, 64'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_clkena"}, {63'd0, lcd_clkena}, 64'd0);
        chk({tag, "_data"}, {49'd0, lcd_data}, 64'd0);
        chk({tag, "_mode"}, {62'd0, lcd_mode}, 64'd0);
        chk({tag, "_on"}, {63'd0, lcd_on}, 64'd0);
        chk({tag, "_ly"}, {56'd0, ly}, 64'd0);
        chk({tag, "_fs"}, {63'd0, frame_start}, 64'd0);
        chk({tag, "_underrun"}, {63'd0, underrun}, 64'd0);
        chk({tag, "_ready"}, {63'd0, pix.pix_ready}, 64'd0);
    endtask

    task automatic line0_checks(input string tag);
        chk({tag, "_l0_strobes"}, 64'(stb_n[0]), 64'(PW));
        chk({tag, "_l0_mode3_dots"}, 64'(m3_n[0]), 64'(PRE + PW));
        chk({tag, "_l0_first_data"}, {49'd0, fd[0]}, 64'd0);
        chk({tag, "_l0_last_data"}, {49'd0, lst[0]}, 64'(PW - 1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int y;
        pix.pix_valid = 1'b0;
        pix.pix_data = '0;
        #1 reset = 1'b1;
        #1 chk_zero("reset");
        @(posedge clk);
        #1 reset = 1'b0;
        // Line 0 from enable: modes 2/3/0 and 160 strobes of 0..159.
        clr();
        src = '0;
        run(LD + 1, 0, 0, 0);
        line0_checks("t1");
        // One full frame: vblank length and frame_start period.
        clr();
        run(FRAME, 0, 0, 0);
        chk("t1_vblank_dots", 64'(m1_cnt), 64'((LN - VL) * LD));
        chk("t1_fs_count", 64'(fs_cnt), 64'd1);
        chk("t1_underrun", {63'd0, underrun}, 64'd0);
        // 20-dot stall after pixel 50 on line 2 stretches mode 3 to dot 271.
        clr();
        run(2 * LD, 0, 1, 2);
        chk("t2_mode3_dots", 64'(m3_n[2]), 64'(PRE + PW + 20));
        chk("t2_strobes", 64'(stb_n[2]), 64'(PW));
        chk("t2_underrun", {63'd0, underrun}, 64'd0);
        // Line 5 starved: padding dots 296..455 with zero data.
        clr();
        run(3 * LD, 0, 2, 5);
        chk("t3_mode3_dots", 64'(m3_n[5]), 64'(LD - OAM));
        chk("t3_strobes", 64'(stb_n[5]), 64'(PW));
        chk("t3_zero_strobes", 64'(zd_n[5]), 64'(PW));
        chk("t3_underrun", {63'd0, underrun}, 64'd1);
        // Disable mid mode 3 at line 10 dot 150, then re-enable.
        run_to(10, 150);
        step(1'b1, 1'b0, 1'b1);
        chk("t4_off_on", {63'd0, lcd_on}, 64'd0);
        chk("t4_off_mode", {62'd0, lcd_mode}, 64'd0);
        chk("t4_off_clkena", {63'd0, lcd_clkena}, 64'd0);
        chk("t4_off_ly", {56'd0, ly}, 64'd0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("t4_on_ly", {56'd0, ly}, 64'd0);
        chk("t4_on_mode", {62'd0, lcd_mode}, 64'd2);
        chk("t4_on_fs", {63'd0, frame_start}, 64'd1);
        chk("t4_on_on", {63'd0, lcd_on}, 64'd1);
        step(1'b0, 1'b1, 1'b1);
        chk("t6_fs_one_clk", {63'd0, frame_start}, 64'd0);
        // ce on every second clk: counts stay in ce ticks.
        clr();
        run(4 * LD, 1, 0, 0);
        chk("t6_mode3_ticks", 64'(m3_n[0]), 64'(PRE + PW));
        chk("t6_l0_strobes", 64'(stb_n[0]), 64'(PW));
        chk("t6_l1_strobes", 64'(stb_n[1]), 64'(PW));
        // Random ce, valid and occasional disables.
        run(6000, 2, 3, 0);
        // Async reset in the middle of mode 3, no clock edge needed.
        y = (m_on && tick / LD < VL - 1) ? tick / LD + 1 : 0;
        run_to(y, 120);
        #2 reset = 1'b1;
        #1 chk_zero("t5");
        m_on = 0; tick = 0; m_px = 0; m_pad = 0; m_und = 0; e_stb = 0; e_fs = 0; have_fs = 0;
        e_data = '0;
        @(posedge clk);
        #1 reset = 1'b0;
        clr();
        src = '0;
        run(LD + 1, 0, 0, 0);
        line0_checks("t5");
        chk("t5_underrun", {63'd0, underrun}, 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
